mem_stall_ctrl: RTL

MEM_STALL_CTRL -- requirements
Module: mem_stall_ctrl

---
 rtl/pipeline_pkg.sv | 17 +
 rtl/mem_wait_counter.sv | 28 ++
 rtl/mem_stall_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: memory-stall FSM encoding and field widths.
package pipeline_pkg;

  // Memory-stall controller states; ERR is only reachable with MEM_TIMEOUT_EN.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StErr  = 2'd2
  } mem_state_e;

  // Width of the MEM/WB write-back control field cleared by a bubble.
  localparam int unsigned WbWidth = 2;

  // Width of the memory wait-cycle counter.
  localparam int unsigned WaitCntWidth = 8;

endpackage

// File: rtl/mem_wait_counter.sv
// Saturating wait-cycle counter for the memory-stall controller.
module mem_wait_counter
  import pipeline_pkg::*;
#(
  parameter int unsigned MAX = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    clr,
  output logic [WaitCntWidth-1:0] count,
  output logic                    sat
);

  assign sat = (count == WaitCntWidth'(MAX));

  // Clear has priority over counting; the count holds once it reaches MAX.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !sat) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_stall_ctrl.sv
// Pipeline stall controller for a data memory with variable latency.
// Optional build macro MEM_TIMEOUT_EN adds the ERR state and the sticky mem_timeout output.
module mem_stall_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic mem_read,
  input  logic mem_write,
  input  logic mem_ack,
  input  logic load_use_hazard,
  output logic mem_req,
  output logic pc_write,
  output logic if_id_write,
  output logic id_ex_write,
  output logic ex_mem_write,
  output logic id_ex_flush,
  output logic mem_wb_bubble,
`ifdef MEM_TIMEOUT_EN
  output logic mem_timeout,
`endif
  output logic mem_busy
);

  mem_state_e              state_q;
  logic                    access;
  logic                    in_idle;
  logic                    in_wait;
  logic                    in_err;
  logic                    mem_stall;
  logic [WaitCntWidth-1:0] wait_cnt;
  logic                    wait_sat;

  assign access  = mem_read | mem_write;
  assign in_idle = (state_q == StIdle);
  assign in_wait = (state_q == StWait);
  assign in_err  = (state_q == StErr);

  // A stall is needed whenever an access is outstanding without an ack, or forever in ERR.
  assign mem_stall = (in_idle & access & ~mem_ack) | (in_wait & ~mem_ack) | in_err;

  mem_wait_counter #(
    .MAX (TIMEOUT_CYCLES)
  ) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (in_wait & ~mem_ack),
    .clr   (~in_wait | mem_ack),
    .count (wait_cnt),
    .sat   (wait_sat)
  );

`ifdef MEM_TIMEOUT_EN
  logic timeout_q;
  logic timeout_hit;
  logic unused_sat;

  assign timeout_hit = (wait_cnt == WaitCntWidth'(TIMEOUT_CYCLES - 1));
  assign mem_timeout = timeout_q;
  assign unused_sat  = wait_sat;
`else
  logic unused_cnt;

  assign unused_cnt = ^{wait_cnt, wait_sat};
`endif

  // State register; ack in IDLE without an access and anything in ERR are ignored.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
`ifdef MEM_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (access && !mem_ack) state_q <= StWait;
        end
        StWait: begin
          if (mem_ack) begin
            state_q <= StIdle;
`ifdef MEM_TIMEOUT_EN
          end else if (timeout_hit) begin
            state_q   <= StErr;
            timeout_q <= 1'b1;
`endif
          end
        end
`ifdef MEM_TIMEOUT_EN
        StErr: state_q <= StErr;
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

  // Stall/flush outputs; the memory stall overrides the load-use hazard.
  always_comb begin
    mem_req       = 1'b0;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    ex_mem_write  = 1'b1;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;
    mem_busy      = 1'b0;
    if (!reset) begin
      id_ex_flush   = 1'b1;
      mem_wb_bubble = 1'b1;
    end else begin
      mem_req  = (in_idle & access) | in_wait;
      mem_busy = in_wait;
      if (mem_stall) begin
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        id_ex_write   = 1'b0;
        ex_mem_write  = 1'b0;
        mem_wb_bubble = 1'b1;
      end else if (load_use_hazard) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

endmodule
